// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared MIPS pipeline constants: opcodes, control-vector bit
//            positions, ALUOp encodings and the main control decoder.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

  // Primary opcodes, IR[31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  // WB vector bit positions
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  // M vector bit positions
  localparam int M_BRANCH   = 2;
  localparam int M_MEMREAD  = 1;
  localparam int M_MEMWRITE = 0;

  // EX vector bit positions
  localparam int EX_REGDST   = 3;
  localparam int EX_ALUOP_HI = 2;
  localparam int EX_ALUOP_LO = 1;
  localparam int EX_ALUSRC   = 0;

  // ALUOp encodings
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic [1:0] wb;
    logic [2:0] m;
    logic [3:0] ex;
  } ctrl_t;

  // Bubble: nothing written, no memory access, no branch
  localparam ctrl_t CTRL_NOP = '{wb: 2'b00, m: 3'b000, ex: 4'b0000};

  // Main control unit; unknown opcodes decode to a bubble
  function automatic ctrl_t decode_ctrl(input logic [5:0] op);
    ctrl_t c;
    c = CTRL_NOP;
    case (op)
      OP_RTYPE: begin
        c.wb[WB_REGWRITE]              = 1'b1;
        c.ex[EX_REGDST]                = 1'b1;
        c.ex[EX_ALUOP_HI:EX_ALUOP_LO]  = ALUOP_FUNCT;
      end
      OP_LW: begin
        c.wb[WB_REGWRITE]              = 1'b1;
        c.wb[WB_MEMTOREG]              = 1'b1;
        c.m[M_MEMREAD]                 = 1'b1;
        c.ex[EX_ALUOP_HI:EX_ALUOP_LO]  = ALUOP_ADD;
        c.ex[EX_ALUSRC]                = 1'b1;
      end
      OP_SW: begin
        c.m[M_MEMWRITE]                = 1'b1;
        c.ex[EX_ALUOP_HI:EX_ALUOP_LO]  = ALUOP_ADD;
        c.ex[EX_ALUSRC]                = 1'b1;
      end
      OP_BEQ: begin
        c.m[M_BRANCH]                  = 1'b1;
        c.ex[EX_ALUOP_HI:EX_ALUOP_LO]  = ALUOP_SUB;
      end
      default: c = CTRL_NOP;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module   : reg_file
// Purpose  : 32 x WIDTH register file, two combinational read ports, one
//            write port, $0 hardwired to zero, optional WB->read bypass.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file #(
  parameter int WIDTH  = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [4:0]       waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [4:0]       raddr_a_i,
  input  logic [4:0]       raddr_b_i,
  output logic [WIDTH-1:0] rdata_a_o,
  output logic [WIDTH-1:0] rdata_b_o
);

  logic [WIDTH-1:0] regs_q [32];
  logic             wr_en;
  logic             fwd_a;
  logic             fwd_b;

  // $0 is never written, so entry 0 stays at its reset value of zero
  assign wr_en = we_i && (waddr_i != 5'd0);

  // Register array: cleared asynchronously, written on the rising edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  generate
    if (BYPASS) begin : g_bypass
      assign fwd_a = wr_en && (waddr_i == raddr_a_i);
      assign fwd_b = wr_en && (waddr_i == raddr_b_i);
    end else begin : g_no_bypass
      assign fwd_a = 1'b0;
      assign fwd_b = 1'b0;
    end
  endgenerate

  // Read ports: $0 reads zero, a same-cycle write wins when bypass is on
  always_comb begin
    rdata_a_o = '0;
    rdata_b_o = '0;
    if (raddr_a_i != 5'd0) rdata_a_o = fwd_a ? wdata_i : regs_q[raddr_a_i];
    if (raddr_b_i != 5'd0) rdata_b_o = fwd_b ? wdata_i : regs_q[raddr_b_i];
  end

endmodule
`default_nettype wire

// File: rtl/i_decode.sv
`default_nettype none
// ============================================================================
// Module   : i_decode
// Purpose  : MIPS ID stage. Decodes IF/ID, reads the register file,
//            sign-extends the immediate and registers the ID/EX latch.
// Revision : 1.0 - initial release
// ============================================================================
module i_decode
  import mips_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      IF_ID_IR,
  input  logic [WIDTH-1:0] IF_ID_NPC,
  input  logic             PCSrc,
  input  logic             MEM_WB_RegWrite,
  input  logic [4:0]       MEM_WB_Writereg,
  input  logic [WIDTH-1:0] MEM_WB_Writedata,
  output logic [1:0]       ID_EX_WB,
  output logic [2:0]       ID_EX_M,
  output logic [3:0]       ID_EX_EX,
  output logic [WIDTH-1:0] ID_EX_NPC,
  output logic [WIDTH-1:0] ID_EX_A,
  output logic [WIDTH-1:0] ID_EX_B,
  output logic [WIDTH-1:0] ID_EX_IMM,
  output logic [4:0]       ID_EX_rt,
  output logic [4:0]       ID_EX_rd
);

  ctrl_t            ctrl_d, ctrl_q;
  logic [WIDTH-1:0] a_d, b_d, imm_d;
  logic [WIDTH-1:0] npc_q, a_q, b_q, imm_q;
  logic [4:0]       rt_q, rd_q;

  reg_file #(
    .WIDTH  (WIDTH),
    .BYPASS (BYPASS)
  ) u_reg_file (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (MEM_WB_RegWrite),
    .waddr_i   (MEM_WB_Writereg),
    .wdata_i   (MEM_WB_Writedata),
    .raddr_a_i (IF_ID_IR[25:21]),
    .raddr_b_i (IF_ID_IR[20:16]),
    .rdata_a_o (a_d),
    .rdata_b_o (b_d)
  );

  assign imm_d = {{(WIDTH-16){IF_ID_IR[15]}}, IF_ID_IR[15:0]};

  // Control decode; a taken branch downstream turns this slot into a bubble
  always_comb begin
    ctrl_d = decode_ctrl(IF_ID_IR[31:26]);
    if (PCSrc) ctrl_d = CTRL_NOP;
  end

  // ID/EX pipeline latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= CTRL_NOP;
      npc_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      imm_q  <= '0;
      rt_q   <= '0;
      rd_q   <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      npc_q  <= IF_ID_NPC;
      a_q    <= a_d;
      b_q    <= b_d;
      imm_q  <= imm_d;
      rt_q   <= IF_ID_IR[20:16];
      rd_q   <= IF_ID_IR[15:11];
    end
  end

  assign ID_EX_WB  = ctrl_q.wb;
  assign ID_EX_M   = ctrl_q.m;
  assign ID_EX_EX  = ctrl_q.ex;
  assign ID_EX_NPC = npc_q;
  assign ID_EX_A   = a_q;
  assign ID_EX_B   = b_q;
  assign ID_EX_IMM = imm_q;
  assign ID_EX_rt  = rt_q;
  assign ID_EX_rd  = rd_q;

endmodule
`default_nettype wire

// File: tb/tb_i_decode.sv
`default_nettype none
// ============================================================================
// Module   : tb_i_decode
// Purpose  : Self-checking bench for the MIPS ID stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i_decode;

  localparam int W      = 32;
  localparam bit BYP    = 1'b1;

  logic         clk;
  logic         rst_n;
  logic [31:0]  IF_ID_IR;
  logic [W-1:0] IF_ID_NPC;
  logic         PCSrc;
  logic         MEM_WB_RegWrite;
  logic [4:0]   MEM_WB_Writereg;
  logic [W-1:0] MEM_WB_Writedata;
  logic [1:0]   ID_EX_WB;
  logic [2:0]   ID_EX_M;
  logic [3:0]   ID_EX_EX;
  logic [W-1:0] ID_EX_NPC, ID_EX_A, ID_EX_B, ID_EX_IMM;
  logic [4:0]   ID_EX_rt, ID_EX_rd;

  i_decode #(.WIDTH(W), .BYPASS(BYP)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .IF_ID_IR         (IF_ID_IR),
    .IF_ID_NPC        (IF_ID_NPC),
    .PCSrc            (PCSrc),
    .MEM_WB_RegWrite  (MEM_WB_RegWrite),
    .MEM_WB_Writereg  (MEM_WB_Writereg),
    .MEM_WB_Writedata (MEM_WB_Writedata),
    .ID_EX_WB         (ID_EX_WB),
    .ID_EX_M          (ID_EX_M),
    .ID_EX_EX         (ID_EX_EX),
    .ID_EX_NPC        (ID_EX_NPC),
    .ID_EX_A          (ID_EX_A),
    .ID_EX_B          (ID_EX_B),
    .ID_EX_IMM        (ID_EX_IMM),
    .ID_EX_rt         (ID_EX_rt),
    .ID_EX_rd         (ID_EX_rd)
  );

  typedef struct {
    logic [1:0]   wb;
    logic [2:0]   m;
    logic [3:0]   ex;
    logic [W-1:0] npc, a, b, imm;
    logic [4:0]   rt, rd;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] mregs [32];
  int           errors = 0;
  int           checks = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference control table
  function automatic logic [8:0] ref_ctrl(input logic [5:0] op);
    case (op)
      6'h00:   return {2'b10, 3'b000, 4'b1100};
      6'h23:   return {2'b11, 3'b010, 4'b0001};
      6'h2B:   return {2'b00, 3'b001, 4'b0001};
      6'h04:   return {2'b00, 3'b100, 4'b0010};
      default: return 9'd0;
    endcase
  endfunction

  function automatic logic [W-1:0] ref_read(input logic [4:0] r, input logic we,
                                            input logic [4:0] wr, input logic [W-1:0] wd);
    if (r == 5'd0) return '0;
    if (BYP && we && wr == r) return wd;
    return mregs[r];
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_WB"},  {30'd0, ID_EX_WB}, 32'd0);
    check({tag, "_M"},   {29'd0, ID_EX_M},  32'd0);
    check({tag, "_EX"},  {28'd0, ID_EX_EX}, 32'd0);
    check({tag, "_NPC"}, ID_EX_NPC, 32'd0);
    check({tag, "_A"},   ID_EX_A,   32'd0);
    check({tag, "_B"},   ID_EX_B,   32'd0);
    check({tag, "_IMM"}, ID_EX_IMM, 32'd0);
    check({tag, "_rt"},  {27'd0, ID_EX_rt}, 32'd0);
    check({tag, "_rd"},  {27'd0, ID_EX_rd}, 32'd0);
  endtask

  // One pipeline step: drive, push expectation, clock, pop and compare
  task automatic step(input string tag, input logic [31:0] ir, input logic [W-1:0] npc,
                      input logic pcs, input logic we, input logic [4:0] wr,
                      input logic [W-1:0] wd);
    exp_t e;
    logic [8:0] c;
    IF_ID_IR = ir; IF_ID_NPC = npc; PCSrc = pcs;
    MEM_WB_RegWrite = we; MEM_WB_Writereg = wr; MEM_WB_Writedata = wd;
    c = pcs ? 9'd0 : ref_ctrl(ir[31:26]);
    e.wb  = c[8:7];
    e.m   = c[6:4];
    e.ex  = c[3:0];
    e.npc = npc;
    e.a   = ref_read(ir[25:21], we, wr, wd);
    e.b   = ref_read(ir[20:16], we, wr, wd);
    e.imm = {{(W-16){ir[15]}}, ir[15:0]};
    e.rt  = ir[20:16];
    e.rd  = ir[15:11];
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (we && wr != 5'd0) mregs[wr] = wd;
    MEM_WB_RegWrite = 1'b0;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_WB"},  {30'd0, ID_EX_WB}, {30'd0, e.wb});
      check({tag, "_M"},   {29'd0, ID_EX_M},  {29'd0, e.m});
      check({tag, "_EX"},  {28'd0, ID_EX_EX}, {28'd0, e.ex});
      check({tag, "_NPC"}, ID_EX_NPC, e.npc);
      check({tag, "_A"},   ID_EX_A,   e.a);
      check({tag, "_B"},   ID_EX_B,   e.b);
      check({tag, "_IMM"}, ID_EX_IMM, e.imm);
      check({tag, "_rt"},  {27'd0, ID_EX_rt}, {27'd0, e.rt});
      check({tag, "_rd"},  {27'd0, ID_EX_rd}, {27'd0, e.rd});
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    rst_n = 1'b0;
    IF_ID_IR = '0; IF_ID_NPC = '0; PCSrc = 1'b0;
    MEM_WB_RegWrite = 1'b0; MEM_WB_Writereg = '0; MEM_WB_Writedata = '0;

    // Reset state, with edges occurring during reset
    #22;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Register dump through both read ports
    for (int i = 0; i < 32; i++) begin
      logic [4:0] r;
      r = 5'(i);
      step($sformatf("dump%0d", i), {6'h00, r, r, 16'h0000}, '0, 1'b0, 1'b0, 5'd0, '0);
    end

    // nop decodes as R-type
    step("nop", 32'h0000_0000, 32'd0, 1'b0, 1'b0, 5'd0, '0);

    // WB writes then add $7,$5,$6
    step("wr5", 32'h0000_0000, 32'd0, 1'b0, 1'b1, 5'd5, 32'h0000_0007);
    step("wr6", 32'h0000_0000, 32'd0, 1'b0, 1'b1, 5'd6, 32'h0000_0003);
    step("add", 32'h00A6_3820, 32'd4, 1'b0, 1'b0, 5'd0, '0);

    // lw $2,-4($5)
    step("lw",  32'h8CA2_FFFC, 32'd8, 1'b0, 1'b0, 5'd0, '0);

    // sw and an unknown opcode (bubble with data still latched)
    step("sw",  32'hACA6_0008, 32'd12, 1'b0, 1'b0, 5'd0, '0);
    step("unk", 32'h08A6_8000, 32'd16, 1'b0, 1'b0, 5'd0, '0);

    // Same-cycle WB write to rs, then to rt
    step("byp_rs",  32'h00A6_3820, 32'd20, 1'b0, 1'b1, 5'd5, 32'h0000_0011);
    step("after_rs", 32'h00A6_3820, 32'd24, 1'b0, 1'b0, 5'd0, '0);
    step("byp_rt",  32'h00A6_3820, 32'd28, 1'b0, 1'b1, 5'd6, 32'h0000_0022);
    step("after_rt", 32'h00A6_3820, 32'd32, 1'b0, 1'b0, 5'd0, '0);

    // beq squashed by PCSrc, then not
    step("beq_sq", 32'h10A6_0003, 32'd36, 1'b1, 1'b0, 5'd0, '0);
    step("beq",    32'h10A6_0003, 32'd40, 1'b0, 1'b0, 5'd0, '0);

    // $0 write ignored, also not forwarded
    step("wr0",   32'h0000_0000, 32'd44, 1'b0, 1'b1, 5'd0, 32'h0000_DEAD);
    step("rd0",   32'h0000_0000, 32'd48, 1'b0, 1'b0, 5'd0, '0);

    // Fill $9, leave nonzero outputs in the latch
    step("wr9",   32'h0125_4820, 32'd52, 1'b0, 1'b1, 5'd9, 32'hCAFE_0009);
    step("rd9",   32'h0125_4820, 32'd56, 1'b0, 1'b0, 5'd0, '0);

    // Asynchronous reset mid-cycle clears outputs before the next edge
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    for (int i = 0; i < 32; i++) mregs[i] = '0;

    // WB write coincident with an edge under reset is dropped
    MEM_WB_RegWrite = 1'b1; MEM_WB_Writereg = 5'd9; MEM_WB_Writedata = 32'h0000_0055;
    IF_ID_IR = 32'h8CA2_FFFC; IF_ID_NPC = 32'd60;
    @(posedge clk); #1;
    check_all_zero("rst_hold");
    MEM_WB_RegWrite = 1'b0;
    rst_n = 1'b1;
    step("post_rst", 32'h0125_4820, 32'd64, 1'b0, 1'b0, 5'd0, '0);
    step("post_rst5", 32'h00A6_3820, 32'd68, 1'b0, 1'b0, 5'd0, '0);

    if (sb.size() != 0) check("sb_leftover", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
